axi_rd_burst_arbiter: RTL and testbench

//  Shares one AXI4 read master port (the s_axi_ar*/r* set) among NREQ burst requesters.

---
 rtl/axi_rd_burst_arbiter.sv | 171 +++++++++++++++++
 tb/tb_axi_rd_burst_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_burst_arbiter.sv
// Round-robin arbiter sharing a single AXI4 read address/data channel among NREQ
// burst requesters; one INCR burst in flight at a time, R beats steered to the grantee.
`timescale 1ns/1ps

module axi_rd_burst_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*LEN_W-1:0]    req_len,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [NREQ-1:0]          rsp_valid,
  output logic                     rsp_last,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [ADDR_W-1:0]        s_axi_araddr,
  output logic [LEN_W-1:0]         s_axi_arlen,
  output logic [1:0]               s_axi_arburst,
  output logic [2:0]               s_axi_arsize,
  output logic                     s_axi_arvalid,
  input  logic                     s_axi_arready,
  input  logic [DATA_W-1:0]        s_axi_rdata,
  input  logic                     s_axi_rvalid,
  output logic                     s_axi_rready,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int GID_W = $clog2(NREQ);
  localparam logic [2:0] ARSIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [GID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [GID_W-1:0]   grant_q, grant_nxt;
  logic [LEN_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [LEN_W-1:0]   arlen_q, arlen_nxt;
  logic [ADDR_W-1:0]  araddr_q, araddr_nxt;

  logic [2*NREQ-1:0]  req_dbl;
  logic [2*NREQ-1:0]  req_rot_full;
  logic [NREQ-1:0]    req_rot;
  logic               found;
  logic [GID_W-1:0]   winner;
  logic [GID_W:0]     win_sum;
  logic [GID_W-1:0]   grant_inc;
  logic               beat_fire;

  // Rotate the request vector so bit 0 is the rr_ptr requester, then take the
  // first set bit and map the offset back to an absolute requester index.
  always_comb begin
    req_dbl      = {req_valid, req_valid};
    req_rot_full = req_dbl >> rr_ptr;
    req_rot      = req_rot_full[NREQ-1:0];
    found        = 1'b0;
    winner       = '0;
    win_sum      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        win_sum = {1'b0, rr_ptr} + (GID_W+1)'(i);
        if (win_sum >= (GID_W+1)'(NREQ)) begin
          win_sum = win_sum - (GID_W+1)'(NREQ);
        end
        winner  = win_sum[GID_W-1:0];
      end
    end
  end

  always_comb begin
    if (grant_q == GID_W'(NREQ - 1)) begin
      grant_inc = '0;
    end else begin
      grant_inc = grant_q + GID_W'(1);
    end
  end

  assign beat_fire = (state == DATA) && s_axi_rvalid && rsp_ready[grant_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      grant_q  <= '0;
      beat_cnt <= '0;
      arlen_q  <= '0;
      araddr_q <= '0;
    end else begin
      rr_ptr   <= rr_ptr_nxt;
      grant_q  <= grant_nxt;
      beat_cnt <= beat_cnt_nxt;
      arlen_q  <= arlen_nxt;
      araddr_q <= araddr_nxt;
    end
  end

  // beat_cnt counts down the remaining beats, so len=all-ones needs no extra bit.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = grant_q;
    beat_cnt_nxt = beat_cnt;
    arlen_nxt    = arlen_q;
    araddr_nxt   = araddr_q;
    req_ready    = '0;
    rsp_valid    = '0;
    s_axi_rready = 1'b0;
    rsp_data     = '0;
    rsp_last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          req_ready[winner] = rst;
          grant_nxt         = winner;
          araddr_nxt        = req_addr[winner*ADDR_W +: ADDR_W];
          arlen_nxt         = req_len[winner*LEN_W +: LEN_W];
          state_nxt         = ADDR;
        end
      end
      ADDR: begin
        if (s_axi_arready) begin
          beat_cnt_nxt = arlen_q;
          state_nxt    = DATA;
        end
      end
      DATA: begin
        rsp_valid[grant_q] = s_axi_rvalid;
        s_axi_rready       = rsp_ready[grant_q];
        rsp_data           = s_axi_rdata;
        rsp_last           = (beat_cnt == '0);
        if (beat_fire) begin
          if (beat_cnt == '0) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = grant_inc;
          end else begin
            beat_cnt_nxt = beat_cnt - LEN_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign s_axi_araddr  = araddr_q;
  assign s_axi_arlen   = arlen_q;
  assign s_axi_arburst = 2'b01;
  assign s_axi_arsize  = ARSIZE;
  assign s_axi_arvalid = (state == ADDR);
  assign busy          = (state != IDLE);
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_axi_rd_burst_arbiter.sv
// Directed bench for axi_rd_burst_arbiter: single bursts, round-robin order, address
// stalls, requester back-pressure, length extremes and reset in the middle of a burst.
`timescale 1ns/1ps

module tb_axi_rd_burst_arbiter;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*LEN_W-1:0]  req_len;
  logic [DATA_W-1:0]      rsp_data;
  logic [NREQ-1:0]        rsp_valid;
  logic                   rsp_last;
  logic [NREQ-1:0]        rsp_ready;
  logic [ADDR_W-1:0]      s_axi_araddr;
  logic [LEN_W-1:0]       s_axi_arlen;
  logic [1:0]             s_axi_arburst;
  logic [2:0]             s_axi_arsize;
  logic                   s_axi_arvalid;
  logic                   s_axi_arready;
  logic [DATA_W-1:0]      s_axi_rdata;
  logic                   s_axi_rvalid;
  logic                   s_axi_rready;
  logic                   busy;
  logic [0:0]             grant_id;

  int total;
  int bad;

  axi_rd_burst_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst), .s_axi_arsize(s_axi_arsize),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic apply_reset();
    rst           = 1'b0;
    req_valid     = '0;
    rsp_ready     = '0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rdata   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Caller presents requests (state IDLE) just after a falling edge; this task
  // walks the grant, address phase (with ar_delay extra stall cycles) and all beats.
  task automatic run_burst(input int exp_id, input logic [15:0] exp_addr,
                           input logic [7:0] exp_len, input int ar_delay,
                           input logic [31:0] data_base);
    logic [NREQ-1:0] onehot;
    onehot = NREQ'(1) << exp_id;
    #1;
    check_output("accept_ready", req_ready, onehot);
    check_output("accept_busy", busy, 0);
    @(negedge clk);
    req_valid[exp_id] = 1'b0;
    s_axi_rvalid      = 1'b1;
    s_axi_rdata       = 32'hDEAD_BEEF;
    #1;
    check_output("ar_valid", s_axi_arvalid, 1);
    check_output("ar_addr", s_axi_araddr, exp_addr);
    check_output("ar_len", s_axi_arlen, exp_len);
    check_output("ar_burst", s_axi_arburst, 2'b01);
    check_output("ar_size", s_axi_arsize, 3'd2);
    check_output("ar_grant", grant_id, exp_id);
    check_output("ar_busy", busy, 1);
    check_output("ar_no_ready", req_ready, 0);
    check_output("ar_no_rready", s_axi_rready, 0);
    check_output("ar_no_rsp", rsp_valid, 0);
    for (int d = 0; d < ar_delay; d++) begin
      @(negedge clk);
      #1;
      check_output("stall_arvalid", s_axi_arvalid, 1);
      check_output("stall_araddr", s_axi_araddr, exp_addr);
      check_output("stall_arlen", s_axi_arlen, exp_len);
      check_output("stall_rready", s_axi_rready, 0);
    end
    s_axi_arready = 1'b1;
    @(negedge clk);
    s_axi_arready = 1'b0;
    for (int b = 0; b <= int'(exp_len); b++) begin
      s_axi_rvalid = 1'b1;
      s_axi_rdata  = data_base + 32'(b);
      rsp_ready    = onehot;
      #1;
      check_output("beat_valid", rsp_valid, onehot);
      check_output("beat_rready", s_axi_rready, 1);
      check_output("beat_data", rsp_data, data_base + 32'(b));
      check_output("beat_last", rsp_last, (b == int'(exp_len)) ? 1 : 0);
      @(negedge clk);
    end
    s_axi_rvalid = 1'b0;
    rsp_ready    = '0;
    #1;
    check_output("done_busy", busy, 0);
    check_output("done_rsp", rsp_valid, 0);
  endtask

  initial begin
    logic [4:0] pat;
    int         k;
    total = 0;
    bad   = 0;
    req_addr = '0;
    req_len  = '0;
    rst           = 1'b0;
    req_valid     = '0;
    rsp_ready     = '0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rdata   = '0;
    @(negedge clk);
    #1;
    check_output("rst_busy", busy, 0);
    check_output("rst_arvalid", s_axi_arvalid, 0);
    check_output("rst_araddr", s_axi_araddr, 0);
    check_output("rst_arlen", s_axi_arlen, 0);
    check_output("rst_grant", grant_id, 0);
    check_output("rst_req_ready", req_ready, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] single requester burst");
    req_valid = 2'b01; req_addr[0 +: 16] = 16'h0040; req_len[0 +: 8] = 8'd3;
    run_burst(0, 16'h0040, 8'd3, 0, 32'hA000_0000);

    $display("[TB] round-robin from reset");
    apply_reset();
    req_valid = 2'b11;
    req_addr[0 +: 16] = 16'h0100; req_len[0 +: 8] = 8'd1;
    req_addr[16 +: 16] = 16'h0200; req_len[8 +: 8] = 8'd1;
    run_burst(0, 16'h0100, 8'd1, 0, 32'hB000_0000);
    req_valid[0] = 1'b1; req_addr[0 +: 16] = 16'h0180;
    run_burst(1, 16'h0200, 8'd1, 0, 32'hB100_0000);
    run_burst(0, 16'h0180, 8'd1, 0, 32'hB200_0000);

    $display("[TB] delayed arready");
    req_valid = 2'b10; req_addr[16 +: 16] = 16'h0440; req_len[8 +: 8] = 8'd1;
    run_burst(1, 16'h0440, 8'd1, 5, 32'hC000_0000);

    $display("[TB] requester back-pressure");
    req_valid = 2'b10; req_addr[16 +: 16] = 16'h0300; req_len[8 +: 8] = 8'd2;
    #1;
    check_output("bp_ready", req_ready, 2'b10);
    @(negedge clk);
    req_valid = '0; s_axi_arready = 1'b1;
    @(negedge clk);
    s_axi_arready = 1'b0;
    pat = 5'b11001;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      rsp_ready    = {pat[c], 1'b0};
      s_axi_rvalid = 1'b1;
      s_axi_rdata  = 32'h0000_00D0 + 32'(k);
      #1;
      check_output("bp_rready", s_axi_rready, pat[c]);
      check_output("bp_valid", rsp_valid, 2'b10);
      check_output("bp_data", rsp_data, 32'h0000_00D0 + 32'(k));
      check_output("bp_last", rsp_last, (k == 2) ? 1 : 0);
      if (pat[c]) k++;
      @(negedge clk);
    end
    s_axi_rvalid = 1'b0; rsp_ready = '0;
    #1;
    check_output("bp_done_busy", busy, 0);

    $display("[TB] length extremes");
    req_valid = 2'b01; req_addr[0 +: 16] = 16'h1000; req_len[0 +: 8] = 8'd0;
    run_burst(0, 16'h1000, 8'd0, 0, 32'hE000_0000);
    req_valid = 2'b01; req_addr[0 +: 16] = 16'h2000; req_len[0 +: 8] = 8'd255;
    run_burst(0, 16'h2000, 8'd255, 0, 32'hF000_0000);

    $display("[TB] reset mid-burst");
    req_valid = 2'b01; req_addr[0 +: 16] = 16'h0600; req_len[0 +: 8] = 8'd3;
    #1;
    check_output("mid_accept", req_ready, 2'b01);
    @(negedge clk);
    req_valid = '0; s_axi_arready = 1'b1;
    @(negedge clk);
    s_axi_arready = 1'b0;
    s_axi_rvalid = 1'b1; rsp_ready = 2'b01; s_axi_rdata = 32'h0000_0600;
    @(negedge clk);
    s_axi_rdata = 32'h0000_0601;
    req_valid = 2'b11;
    #1;
    check_output("mid_beat2_valid", rsp_valid, 2'b01);
    rst = 1'b0;
    #1;
    check_output("mid_rst_busy", busy, 0);
    check_output("mid_rst_rsp_valid", rsp_valid, 0);
    check_output("mid_rst_rready", s_axi_rready, 0);
    check_output("mid_rst_arvalid", s_axi_arvalid, 0);
    check_output("mid_rst_req_ready", req_ready, 0);
    check_output("mid_rst_araddr", s_axi_araddr, 0);
    check_output("mid_rst_data", rsp_data, 0);
    check_output("mid_rst_last", rsp_last, 0);
    @(negedge clk);
    rst = 1'b1;
    s_axi_rvalid = 1'b0; rsp_ready = '0;
    req_valid = 2'b11;
    req_addr[0 +: 16] = 16'h0700; req_len[0 +: 8] = 8'd0;
    req_addr[16 +: 16] = 16'h0800; req_len[8 +: 8] = 8'd0;
    run_burst(0, 16'h0700, 8'd0, 0, 32'h7000_0000);
    run_burst(1, 16'h0800, 8'd0, 0, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
